// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus F/D pipeline register.
// J/JAL are resolved here, so unconditional jumps never need an execute-stage redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          IMEM_ADDR_W = 12
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic                   imem_req,
  input  logic [31:0]            imem_rdata,
  input  logic                   imem_ready,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   fd_valid,
  output logic [31:0]            fd_insn,
  output logic [31:0]            fd_pc,
  output logic [31:0]            fd_pc_plus1,
  output logic                   fd_early_jump,
  output logic [31:0]            pc_out
);

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] fpc1_q, fpc1_d;
  logic        ej_q, ej_d;

  logic [4:0]  opcode;
  logic        is_jump;
  logic [31:0] pc_plus1;

  assign opcode   = imem_rdata[31:27];
  assign is_jump  = (opcode == OP_J) || (opcode == OP_JAL);
  assign pc_plus1 = pc_q + 32'd1;

  // Priority: redirect > stall > memory wait > normal fetch.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    insn_d  = insn_q;
    fpc_d   = fpc_q;
    fpc1_d  = fpc1_q;
    ej_d    = ej_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      insn_d  = 32'd0;
      ej_d    = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (!imem_ready) begin
      valid_d = 1'b0;
      insn_d  = 32'd0;
      ej_d    = 1'b0;
    end else begin
      valid_d = 1'b1;
      insn_d  = imem_rdata;
      fpc_d   = pc_q;
      fpc1_d  = pc_plus1;
      if (is_jump) begin
        pc_d = {5'b0, imem_rdata[26:0]};
        ej_d = 1'b1;
      end else begin
        pc_d = pc_plus1;
        ej_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      insn_q  <= 32'd0;
      fpc_q   <= 32'd0;
      fpc1_q  <= 32'd0;
      ej_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      insn_q  <= insn_d;
      fpc_q   <= fpc_d;
      fpc1_q  <= fpc1_d;
      ej_q    <= ej_d;
    end
  end

  assign imem_addr     = pc_q[IMEM_ADDR_W-1:0];
  assign imem_req      = reset_n & ~stall;
  assign fd_valid      = valid_q;
  assign fd_insn       = insn_q;
  assign fd_pc         = fpc_q;
  assign fd_pc_plus1   = fpc1_q;
  assign fd_early_jump = ej_q;
  assign pc_out        = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'd0;
  localparam int          AW     = 12;

  logic          clock;
  logic          reset_n;
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic [31:0]   imem_rdata;
  logic          imem_ready;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          fd_valid;
  logic [31:0]   fd_insn;
  logic [31:0]   fd_pc;
  logic [31:0]   fd_pc_plus1;
  logic          fd_early_jump;
  logic [31:0]   pc_out;

  logic [31:0] mem [4096];
  assign imem_rdata = mem[imem_addr];

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_pc, m_insn, m_fpc, m_fpc1;
  logic        m_valid, m_ej;

  fetch_stage #(.RESET_PC(RST_PC), .IMEM_ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fd_valid(fd_valid), .fd_insn(fd_insn), .fd_pc(fd_pc),
    .fd_pc_plus1(fd_pc_plus1), .fd_early_jump(fd_early_jump), .pc_out(pc_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rand_nonjump();
    logic [31:0] w;
    w = $urandom;
    if (w[31:27] == 5'b00001 || w[31:27] == 5'b00011) w[31:27] = 5'b00010;
    return w;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_valid = 0; m_insn = 0; m_fpc = 0; m_fpc1 = 0; m_ej = 0;
  endtask

  task automatic model_edge();
    logic [31:0] rd;
    rd = mem[m_pc[AW-1:0]];
    if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 0; m_insn = 0; m_ej = 0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (!imem_ready) begin
      m_valid = 0; m_insn = 0; m_ej = 0;
    end else begin
      m_valid = 1; m_insn = rd; m_fpc = m_pc; m_fpc1 = m_pc + 32'd1;
      if (rd[31:27] inside {5'b00001, 5'b00011}) begin
        m_pc = {5'b0, rd[26:0]}; m_ej = 1;
      end else begin
        m_pc = m_pc + 32'd1; m_ej = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0; imem_ready = 1;
    model_reset();
    @(negedge clock);
    #1;
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0; imem_ready = 1;
    #2;
    checks++; if (pc_out !== RST_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, RST_PC); end
    checks++; if (fd_valid !== 1'b0) begin errors++; $display("FAIL reset_fd_valid got %b want 0", fd_valid); end
    checks++; if (fd_insn !== 32'd0 || fd_pc !== 32'd0 || fd_pc_plus1 !== 32'd0) begin errors++; $display("FAIL reset_fd got insn %h pc %h pc1 %h want 0", fd_insn, fd_pc, fd_pc_plus1); end
    checks++; if (fd_early_jump !== 1'b0) begin errors++; $display("FAIL reset_ej got %b want 0", fd_early_jump); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fd_valid !== 1'b1 || fd_pc !== 32'(i) || fd_pc_plus1 !== 32'(i + 1)) begin errors++; $display("FAIL seq_fd[%0d] got v %b pc %h pc1 %h want 1 %h %h", i, fd_valid, fd_pc, fd_pc_plus1, i, i + 1); end
      checks++; if (pc_out !== 32'(i + 1) || fd_early_jump !== 1'b0) begin errors++; $display("FAIL seq_pc[%0d] got pc %h ej %b want %h 0", i, pc_out, fd_early_jump, i + 1); end
      checks++; if (fd_insn !== mem[i]) begin errors++; $display("FAIL seq_insn[%0d] got %h want %h", i, fd_insn, mem[i]); end
      $display("seq fetch pc=%0d insn=%h", i, mem[i]);
    end
  endtask

  task automatic test_early_jump();
    mem[5] = 32'h0800_0040;
    tick(); tick();
    tick();
    checks++; if (pc_out !== 32'd64) begin errors++; $display("FAIL ej_pc got %h want 40", pc_out); end
    checks++; if (fd_insn !== 32'h0800_0040 || fd_early_jump !== 1'b1) begin errors++; $display("FAIL ej_fd got insn %h ej %b want 08000040 1", fd_insn, fd_early_jump); end
    checks++; if (fd_pc_plus1 !== 32'd6 || imem_addr !== 12'd64) begin errors++; $display("FAIL ej_link got pc1 %h addr %h want 6 40", fd_pc_plus1, imem_addr); end
    $display("early jump J 64 at pc 5");
  endtask

  task automatic test_stall();
    redirect_valid = 1; redirect_pc = 32'd9;
    tick();
    redirect_valid = 0;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b want 0", i, imem_req); end
      tick();
      checks++; if (pc_out !== 32'd10 || fd_valid !== 1'b1 || fd_pc !== 32'd9 || fd_insn !== mem[9]) begin errors++; $display("FAIL stall_hold[%0d] got pc %h v %b fpc %h insn %h want a 1 9 %h", i, pc_out, fd_valid, fd_pc, fd_insn, mem[9]); end
    end
    stall = 0;
    tick();
    checks++; if (fd_pc !== 32'd10 || pc_out !== 32'd11) begin errors++; $display("FAIL stall_resume got fpc %h pc %h want a b", fd_pc, pc_out); end
    $display("stall 3 cycles at pc 10");
  endtask

  task automatic test_redirect_during_stall();
    stall = 1; redirect_valid = 1; redirect_pc = 32'd200;
    tick();
    stall = 0; redirect_valid = 0;
    checks++; if (pc_out !== 32'd200 || fd_valid !== 1'b0 || fd_insn !== 32'd0) begin errors++; $display("FAIL redir_stall got pc %h v %b insn %h want c8 0 0", pc_out, fd_valid, fd_insn); end
    $display("redirect to 200 during stall");
  endtask

  task automatic test_mem_wait();
    redirect_valid = 1; redirect_pc = 32'd7;
    tick();
    redirect_valid = 0; imem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc_out !== 32'd7 || fd_valid !== 1'b0) begin errors++; $display("FAIL wait[%0d] got pc %h v %b want 7 0", i, pc_out, fd_valid); end
    end
    imem_ready = 1;
    tick();
    checks++; if (fd_pc !== 32'd7 || pc_out !== 32'd8 || fd_valid !== 1'b1) begin errors++; $display("FAIL wait_resume got fpc %h pc %h v %b want 7 8 1", fd_pc, pc_out, fd_valid); end
    $display("memory wait 2 cycles at pc 7");
  endtask

  task automatic test_wrap_async_reset();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 0;
    tick();
    checks++; if (pc_out !== 32'd0 || fd_pc !== 32'hFFFF_FFFF || fd_pc_plus1 !== 32'd0) begin errors++; $display("FAIL wrap got pc %h fpc %h pc1 %h want 0 ffffffff 0", pc_out, fd_pc, fd_pc_plus1); end
    tick();
    stall = 1;
    @(negedge clock);
    #2 reset_n = 0;
    #1;
    checks++; if (pc_out !== RST_PC || fd_valid !== 1'b0 || fd_pc !== 32'd0 || imem_req !== 1'b0) begin errors++; $display("FAIL async_reset got pc %h v %b fpc %h req %b want %h 0 0 0", pc_out, fd_valid, fd_pc, imem_req, RST_PC); end
    model_reset();
    stall = 0;
    @(negedge clock);
    reset_n = 1;
    $display("wrap to 0 then async reset");
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(7) == 0)
        mem[$urandom_range(4095)] = {($urandom_range(1) != 0) ? 5'b00011 : 5'b00001, 27'($urandom_range(4095))};
      stall          = ($urandom_range(4) == 0);
      redirect_valid = ($urandom_range(9) == 0);
      redirect_pc    = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(3)) : 32'($urandom_range(4095));
      imem_ready     = ($urandom_range(4) != 0);
      #1;
      checks++; if (imem_req !== ~stall) begin errors++; $display("FAIL rnd_req[%0d] got %b want %b", n, imem_req, ~stall); end
      tick();
      checks++; if (pc_out !== m_pc || imem_addr !== m_pc[AW-1:0]) begin errors++; $display("FAIL rnd_pc[%0d] got %h addr %h want %h", n, pc_out, imem_addr, m_pc); end
      checks++; if (fd_valid !== m_valid || fd_insn !== m_insn || fd_early_jump !== m_ej) begin errors++; $display("FAIL rnd_fd[%0d] got v %b insn %h ej %b want %b %h %b", n, fd_valid, fd_insn, fd_early_jump, m_valid, m_insn, m_ej); end
      checks++; if (fd_pc !== m_fpc || fd_pc_plus1 !== m_fpc1) begin errors++; $display("FAIL rnd_fpc[%0d] got %h %h want %h %h", n, fd_pc, fd_pc_plus1, m_fpc, m_fpc1); end
      $display("rnd %0d st=%b rd=%b rdy=%b pc=%h fd_v=%b", n, stall, redirect_valid, imem_ready, m_pc, m_valid);
    end
    stall = 0; redirect_valid = 0; imem_ready = 1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = rand_nonjump();
    model_reset();
    test_reset();
    test_sequential();
    test_early_jump();
    test_stall();
    test_redirect_during_stall();
    test_mem_wait();
    test_wrap_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
